// File: rtl/sim_reset_finish_ctrl.sv
// Design-side reset stretcher, soft-reset handshake and finish-request controller
// for the simulation harness.
module sim_reset_finish_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES = 20,
    parameter int unsigned COUNT_WIDTH       = 32,
    parameter int unsigned TIMEOUT_CYCLES    = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   soft_rst_req,
    output logic                   soft_rst_ack,
    output logic                   rst_out,
    output logic                   rst_done,
    input  logic                   done_in,
    output logic                   finish_req,
    input  logic                   finish_ack,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic                   timeout
);

    localparam int unsigned HOLD_EFF = (RESET_HOLD_CYCLES == 0) ? 1 : RESET_HOLD_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_EFF + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EFF - 1);
    localparam logic [COUNT_WIDTH-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StHold,
        StRun,
        StSoft,
        StAck,
        StFinish,
        StHalt
    } state_t;

    state_t                 r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_rst_out;
    logic                   r_ack;
    logic                   r_finish_req;
    logic [COUNT_WIDTH-1:0] r_cycle_count;
    logic                   r_timeout;
    logic                   r_armed;

    logic [COUNT_WIDTH-1:0] w_cnt_inc;
    logic                   w_hold_last;
    logic                   w_timeout_hit;

    assign w_cnt_inc   = (&r_cycle_count) ? r_cycle_count : r_cycle_count + COUNT_WIDTH'(1);
    assign w_hold_last = (r_hold_cnt == HOLD_LAST);
    // The first RUN cycle after HOLD still has rst_out high and is not a run cycle.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cycle_count == TO_LAST) && !r_rst_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= StHold;
            r_hold_cnt    <= '0;
            r_rst_out     <= 1'b1;
            r_ack         <= 1'b0;
            r_finish_req  <= 1'b0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_armed       <= 1'b1;
        end else begin
            // A new soft reset needs the request to have been seen low first.
            if (!soft_rst_req) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                StHold: begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    if (w_hold_last) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (!r_rst_out) begin
                        r_cycle_count <= w_cnt_inc;
                    end
                    r_rst_out <= 1'b0;
                    if (done_in) begin
                        r_finish_req <= 1'b1;
                        r_state      <= StFinish;
                    end else if (w_timeout_hit) begin
                        r_timeout    <= 1'b1;
                        r_finish_req <= 1'b1;
                        r_state      <= StFinish;
                    end else if (soft_rst_req && r_armed) begin
                        r_rst_out     <= 1'b1;
                        r_cycle_count <= '0;
                        r_hold_cnt    <= '0;
                        r_armed       <= 1'b0;
                        r_state       <= StSoft;
                    end
                end
                StSoft: begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    if (w_hold_last) begin
                        r_rst_out <= 1'b0;
                        r_ack     <= 1'b1;
                        r_state   <= StAck;
                    end
                end
                StAck: begin
                    r_cycle_count <= w_cnt_inc;
                    if (done_in) begin
                        r_ack        <= 1'b0;
                        r_finish_req <= 1'b1;
                        r_state      <= StFinish;
                    end else if (w_timeout_hit) begin
                        r_ack        <= 1'b0;
                        r_timeout    <= 1'b1;
                        r_finish_req <= 1'b1;
                        r_state      <= StFinish;
                    end else if (!soft_rst_req) begin
                        r_ack   <= 1'b0;
                        r_state <= StRun;
                    end
                end
                StFinish: begin
                    r_rst_out <= 1'b0;
                    if (finish_ack) begin
                        r_finish_req <= 1'b0;
                        r_state      <= StHalt;
                    end
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: begin
                    r_state <= StHold;
                end
            endcase
        end
    end

    assign soft_rst_ack = r_ack;
    assign rst_out      = r_rst_out;
    assign rst_done     = ~r_rst_out;
    assign finish_req   = r_finish_req;
    assign cycle_count  = r_cycle_count;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_sim_reset_finish_ctrl.sv
// Directed bench for sim_reset_finish_ctrl: reset stretch, soft reset, finish handshake,
// priority, mid-operation reset (instance A) and timeout (instance B).
module tb_sim_reset_finish_ctrl;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, soft_a = 1'b0, done_a = 1'b0, fack_a = 1'b0;
    logic        rst_b = 1'b1, soft_b = 1'b0, done_b = 1'b0, fack_b = 1'b0;
    logic        ack_a, ro_a, rd_a, freq_a, to_a;
    logic        ack_b, ro_b, rd_b, freq_b, to_b;
    logic [31:0] cnt_a, cnt_b;

    int n_err    = 0;
    int n_checks = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [36:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    sim_reset_finish_ctrl #(
        .RESET_HOLD_CYCLES(4),
        .COUNT_WIDTH      (32),
        .TIMEOUT_CYCLES   (0)
    ) dut_a (
        .CLK         (clk),
        .RST         (rst_a),
        .soft_rst_req(soft_a),
        .soft_rst_ack(ack_a),
        .rst_out     (ro_a),
        .rst_done    (rd_a),
        .done_in     (done_a),
        .finish_req  (freq_a),
        .finish_ack  (fack_a),
        .cycle_count (cnt_a),
        .timeout     (to_a)
    );

    sim_reset_finish_ctrl #(
        .RESET_HOLD_CYCLES(4),
        .COUNT_WIDTH      (32),
        .TIMEOUT_CYCLES   (10)
    ) dut_b (
        .CLK         (clk),
        .RST         (rst_b),
        .soft_rst_req(soft_b),
        .soft_rst_ack(ack_b),
        .rst_out     (ro_b),
        .rst_done    (rd_b),
        .done_in     (done_b),
        .finish_req  (freq_b),
        .finish_ack  (fack_b),
        .cycle_count (cnt_b),
        .timeout     (to_b)
    );

    // Snapshot layout: {rst_out, rst_done, soft_rst_ack, finish_req, timeout, cycle_count}
    function automatic logic [36:0] mk(input logic ro, input logic rd, input logic ak,
                                       input logic fr, input logic tmo, input int cnt);
        return {ro, rd, ak, fr, tmo, 32'(cnt)};
    endfunction

    function automatic logic [36:0] snap(input bit sel);
        if (sel) return {ro_b, rd_b, ack_b, freq_b, to_b, cnt_b};
        return {ro_a, rd_a, ack_a, freq_a, to_a, cnt_a};
    endfunction

    task automatic chk();
        sb_item_t    it;
        logic [36:0] obs;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed=output expected=queued entry");
            return;
        end
        it  = sb_q.pop_front();
        obs = snap(it.sel);
        assert (obs === it.exp) else begin
            n_err++;
            $error("FAIL %s: observed ro/rd/ack/freq/to=%b cnt=%0d expected %b cnt=%0d",
                   it.tag, obs[36:32], obs[31:0], it.exp[36:32], it.exp[31:0]);
        end
    endtask

    // Queue the expected outputs for the next edge, clock once, then compare.
    task automatic step(input string tag, input bit sel, input logic [36:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
        chk();
    endtask

    initial begin
        // Reset stretch
        for (int i = 0; i < 3; i++) step($sformatf("a_reset_%0d", i), 1'b0, mk(1, 0, 0, 0, 0, 0));
        rst_a = 1'b0;
        for (int i = 1; i <= 4; i++) step($sformatf("a_hold_%0d", i), 1'b0, mk(1, 0, 0, 0, 0, 0));
        step("a_release", 1'b0, mk(0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) step($sformatf("a_run_%0d", k), 1'b0, mk(0, 1, 0, 0, 0, k));

        // Soft reset at cycle_count=10, request held through ACK
        soft_a = 1'b1;
        step("a_soft_enter", 1'b0, mk(1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) step($sformatf("a_soft_%0d", i), 1'b0, mk(1, 0, 0, 0, 0, 0));
        step("a_soft_ack_rise", 1'b0, mk(0, 1, 1, 0, 0, 0));
        for (int k = 1; k <= 3; k++) step($sformatf("a_ack_hold_%0d", k), 1'b0, mk(0, 1, 1, 0, 0, k));
        soft_a = 1'b0;
        step("a_ack_fall", 1'b0, mk(0, 1, 0, 0, 0, 4));
        step("a_run_after_ack", 1'b0, mk(0, 1, 0, 0, 0, 5));

        // Stray finish_ack in RUN, then finish handshake
        fack_a = 1'b1;
        step("a_stray_fack", 1'b0, mk(0, 1, 0, 0, 0, 6));
        fack_a = 1'b0;
        step("a_run_7", 1'b0, mk(0, 1, 0, 0, 0, 7));
        done_a = 1'b1;
        step("a_finish_1", 1'b0, mk(0, 1, 0, 1, 0, 8));
        done_a = 1'b0;
        step("a_finish_2", 1'b0, mk(0, 1, 0, 1, 0, 8));
        step("a_finish_3", 1'b0, mk(0, 1, 0, 1, 0, 8));
        fack_a = 1'b1;
        step("a_halt", 1'b0, mk(0, 1, 0, 0, 0, 8));
        fack_a = 1'b0;
        soft_a = 1'b1;
        done_a = 1'b1;
        step("a_halt_hold_1", 1'b0, mk(0, 1, 0, 0, 0, 8));
        step("a_halt_hold_2", 1'b0, mk(0, 1, 0, 0, 0, 8));
        soft_a = 1'b0;
        done_a = 1'b0;

        // Leave HALT via RST, then done_in and soft_rst_req together
        rst_a = 1'b1;
        step("a_halt_reset", 1'b0, mk(1, 0, 0, 0, 0, 0));
        rst_a = 1'b0;
        for (int i = 1; i <= 4; i++) step($sformatf("a_hold2_%0d", i), 1'b0, mk(1, 0, 0, 0, 0, 0));
        step("a_release2", 1'b0, mk(0, 1, 0, 0, 0, 0));
        done_a = 1'b1;
        soft_a = 1'b1;
        step("a_prio_finish", 1'b0, mk(0, 1, 0, 1, 0, 1));
        done_a = 1'b0;
        soft_a = 1'b0;
        step("a_prio_hold", 1'b0, mk(0, 1, 0, 1, 0, 1));

        // RST in FINISH
        rst_a = 1'b1;
        step("a_finish_reset", 1'b0, mk(1, 0, 0, 0, 0, 0));
        rst_a = 1'b0;
        for (int i = 1; i <= 4; i++) step($sformatf("a_hold3_%0d", i), 1'b0, mk(1, 0, 0, 0, 0, 0));
        step("a_release3", 1'b0, mk(0, 1, 0, 0, 0, 0));
        step("a_run3_1", 1'b0, mk(0, 1, 0, 0, 0, 1));
        step("a_run3_2", 1'b0, mk(0, 1, 0, 0, 0, 2));

        // RST in SOFT at hold count 2
        soft_a = 1'b1;
        step("a_soft2_enter", 1'b0, mk(1, 0, 0, 0, 0, 0));
        soft_a = 1'b0;
        step("a_soft2_1", 1'b0, mk(1, 0, 0, 0, 0, 0));
        step("a_soft2_2", 1'b0, mk(1, 0, 0, 0, 0, 0));
        rst_a = 1'b1;
        step("a_soft_reset", 1'b0, mk(1, 0, 0, 0, 0, 0));
        rst_a = 1'b0;
        for (int i = 1; i <= 4; i++) step($sformatf("a_hold4_%0d", i), 1'b0, mk(1, 0, 0, 0, 0, 0));
        step("a_release4", 1'b0, mk(0, 1, 0, 0, 0, 0));
        step("a_run4_1", 1'b0, mk(0, 1, 0, 0, 0, 1));

        // Timeout instance
        step("b_reset", 1'b1, mk(1, 0, 0, 0, 0, 0));
        rst_b = 1'b0;
        for (int i = 1; i <= 4; i++) step($sformatf("b_hold_%0d", i), 1'b1, mk(1, 0, 0, 0, 0, 0));
        step("b_release", 1'b1, mk(0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) step($sformatf("b_run_%0d", k), 1'b1, mk(0, 1, 0, 0, 0, k));
        step("b_timeout", 1'b1, mk(0, 1, 0, 1, 1, 10));
        fack_b = 1'b1;
        step("b_halt", 1'b1, mk(0, 1, 0, 0, 1, 10));
        fack_b = 1'b0;
        step("b_halt_hold_1", 1'b1, mk(0, 1, 0, 0, 1, 10));
        step("b_halt_hold_2", 1'b1, mk(0, 1, 0, 0, 1, 10));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
